// File: rtl/param_fifo_gen_pkg.sv
// Shared types and helpers for the parametrised show-ahead FIFO.
// Pointer arithmetic is written so that any depth, not only powers of two, wraps correctly.
package param_fifo_gen_pkg;

    typedef struct packed {
        logic full;
        logic afull;
        logic empty;
        logic aempty;
        logic ovf;
        logic unf;
    } fifo_status_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Compare-and-clear wrap keeps non-power-of-two depths from aliasing.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/param_fifo_gen_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; occupancy logic in the top decides what is valid.
module param_fifo_gen_mem
    import param_fifo_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo_generator.sv
// Parametrised first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow and synchronous flush.
module param_fifo_generator
    import param_fifo_gen_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    localparam int CW       = count_width(DEPTH)
) (
    input  logic             ARES_design_CLK,
    input  logic             ARES_design_RESET,
    input  logic [WIDTH-1:0] ARES_design_WData,
    input  logic             ARES_design_Write,
    output logic             ARES_design_Full,
    output logic             ARES_design_AlmostFull,
    output logic [WIDTH-1:0] ARES_design_RData,
    input  logic             ARES_design_Read,
    output logic             ARES_design_Empty,
    output logic             ARES_design_AlmostEmpty,
    output logic [CW-1:0]    ARES_design_Count,
    input  logic             ARES_design_Flush,
    output logic             ARES_design_Overflow,
    output logic             ARES_design_Underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             unf;
    logic             wr_acc;
    logic             rd_acc;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    // Every flag is a pure decode of registered state, so none of them can glitch from inputs.
    assign ARES_design_Full        = (count == DEPTH_C);
    assign ARES_design_Empty       = (count == '0);
    assign ARES_design_AlmostFull  = (count >= AF_C);
    assign ARES_design_AlmostEmpty = (count <= AE_C);
    assign ARES_design_Count       = count;
    assign ARES_design_Overflow    = ovf;
    assign ARES_design_Underflow   = unf;

    assign wr_acc = ARES_design_Write & (~ARES_design_Full | ARES_design_Read);
    assign rd_acc = ARES_design_Read & ~ARES_design_Empty;
    assign mem_we = wr_acc & ~ARES_design_Flush;

    assign wr_ptr_nxt = PW'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));
    assign rd_ptr_nxt = PW'(ptr_inc(32'(rd_ptr), 32'(DEPTH)));

    always_ff @(posedge ARES_design_CLK or negedge ARES_design_RESET) begin
        if (!ARES_design_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (ARES_design_Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
            // Errors are sticky: only reset or flush clears them.
            if (ARES_design_Write && !wr_acc) begin
                ovf <= 1'b1;
            end
            if (ARES_design_Read && !rd_acc) begin
                unf <= 1'b1;
            end
        end
    end

    param_fifo_gen_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (ARES_design_CLK),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (ARES_design_WData),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    assign ARES_design_RData = ARES_design_Empty ? '0 : mem_rdata;

endmodule
